// File: rtl/my_mul16.sv
// Sequential shift-and-add multiplier: one conditional add per cycle, returning the
// low WIDTH bits of a*b behind valid/ready handshakes on both sides.
`timescale 1ns/1ps
module my_mul16 #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] out_reg;
  logic [3:0]       cnt_reg;
  logic             out_valid_reg;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mplier_next;
  logic             last_iter;

  // Wrap-around adder; the carry out of the top bit is simply dropped.
  assign sum         = acc_reg + mcand_reg;
  assign acc_next    = mplier_reg[0] ? sum : acc_reg;
  assign mplier_next = mplier_reg >> 1;
  assign last_iter   = (cnt_reg == 4'(WIDTH-1)) || (EARLY_EXIT && (mplier_next == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      cnt_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_next;
          cnt_reg    <= cnt_reg + 4'd1;
          // The result is published on the same edge as the final add.
          if (last_iter) begin
            out_reg       <= acc_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign out       = out_reg;

endmodule

// File: tb/tb_my_mul16.sv
// Bench for my_mul16: two instances (early exit on/off) share stimulus; directed
// table, back-pressure and reset sequences, then randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_my_mul16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ir_e, ov_e, busy_e, ir_f, ov_f, busy_f;
  logic [15:0] out_e, out_f;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  my_mul16 #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_e), .a(a), .b(b),
    .out_valid(ov_e), .out_ready(out_ready), .out(out_e), .busy(busy_e)
  );

  my_mul16 #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut_f (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_f), .a(a), .b(b),
    .out_valid(ov_f), .out_ready(out_ready), .out(out_f), .busy(busy_f)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] prod;
    int          k;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    longint p;
    p = longint'(x) * longint'(y);
    return p[15:0];
  endfunction

  // One complete operation with out_ready held low until both instances finish.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [15:0] exp, input int ke, input string tag);
    int edge_n, got_e, got_f;
    @(negedge clk);
    chk({tag, " in_ready_e"}, int'(ir_e), 1);
    chk({tag, " in_ready_f"}, int'(ir_f), 1);
    a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    edge_n = 0; got_e = -1; got_f = -1;
    while ((got_e < 0 || got_f < 0) && edge_n < 40) begin
      @(posedge clk);
      #1;
      edge_n++;
      if (ov_e && got_e < 0) got_e = edge_n;
      if (ov_f && got_f < 0) got_f = edge_n;
    end
    chk({tag, " latency_e"}, got_e, ke);
    chk({tag, " latency_f"}, got_f, 16);
    chk({tag, " out_e"}, int'(out_e), int'(exp));
    chk({tag, " out_f"}, int'(out_f), int'(exp));
    $display("op %s: a=0x%04h b=0x%04h out_e=0x%04h@%0d out_f=0x%04h@%0d",
             tag, ta, tb_v, out_e, got_e, out_f, got_f);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " release ov_e"}, int'(ov_e), 0);
    chk({tag, " release ov_f"}, int'(ov_f), 0);
    chk({tag, " release busy_e"}, int'(busy_e), 0);
    chk({tag, " release busy_f"}, int'(busy_f), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] q_e[$];
    logic [15:0] q_f[$];
    logic [15:0] exp_v;
    int n_e, n_f, waited;

    tbl[0] = '{16'h0003, 16'h0005, 16'h000F, 3};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16};
    tbl[2] = '{16'd300,  16'd300,  16'h5F90, 9};
    tbl[3] = '{16'hFFFD, 16'h0005, 16'hFFF1, 3};
    tbl[4] = '{16'h1234, 16'h0000, 16'h0000, 1};
    tbl[5] = '{16'h0007, 16'h8000, 16'h8000, 16};
    tbl[6] = '{16'h00FF, 16'h0101, 16'hFFFF, 9};
    tbl[7] = '{16'h0002, 16'h0002, 16'h0004, 2};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset in_ready_e", int'(ir_e), 1);
    chk("reset in_ready_f", int'(ir_f), 1);
    chk("reset out_valid_e", int'(ov_e), 0);
    chk("reset busy_e", int'(busy_e), 0);
    chk("reset out_e", int'(out_e), 0);
    chk("reset out_f", int'(out_f), 0);

    foreach (tbl[i])
      run_op(tbl[i].a, tbl[i].b, tbl[i].prod, tbl[i].k, $sformatf("tbl%0d", i));

    // Back-pressure: hold the result while in_valid pulses are ignored
    @(negedge clk);
    a = 16'd9; b = 16'd6; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waited = 0;
    while (!(ov_e && ov_f) && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("bp wait", waited, 16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk);
      #1;
      chk("bp hold ov_e", int'(ov_e), 1);
      chk("bp hold out_e", int'(out_e), 54);
      chk("bp hold ov_f", int'(ov_f), 1);
      chk("bp hold out_f", int'(out_f), 54);
      chk("bp in_ready_e", int'(ir_e), 0);
      chk("bp in_ready_f", int'(ir_f), 0);
    end
    $display("op bp: a=0x0009 b=0x0006 held out_e=0x%04h out_f=0x%04h", out_e, out_f);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release ov_e", int'(ov_e), 0);
    chk("bp release in_ready_e", int'(ir_e), 1);
    chk("bp release ov_f", int'(ov_f), 0);
    out_ready = 1'b0;
    run_op(16'd2, 16'd3, 16'd6, 2, "after_bp");

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    a = 16'h1234; b = 16'h00FF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset ov_e", int'(ov_e), 0);
    chk("midreset out_e", int'(out_e), 0);
    chk("midreset busy_e", int'(busy_e), 0);
    chk("midreset ov_f", int'(ov_f), 0);
    chk("midreset out_f", int'(out_f), 0);
    chk("midreset busy_f", int'(busy_f), 0);
    $display("op midreset: a=0x1234 b=0x00FF abandoned at edge 4");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd2, 16'd2, 16'd4, 2, "post_reset");

    // Randomized traffic: handshakes decided from values stable before each edge
    n_e = 0; n_f = 0;
    for (int cyc = 0; cyc < 25040; cyc++) begin
      @(negedge clk);
      a = 16'($urandom);
      b = ($urandom_range(0, 1) == 0) ? 16'($urandom) : (16'($urandom) >> $urandom_range(0, 15));
      if (cyc < 25000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      if (in_valid && ir_e) q_e.push_back(ref_mul(a, b));
      if (in_valid && ir_f) q_f.push_back(ref_mul(a, b));
      if (ov_e && out_ready) begin
        if (q_e.size() == 0) chk("rand_e unexpected result", 1, 0);
        else begin
          exp_v = q_e.pop_front();
          chk("rand_e out", int'(out_e), int'(exp_v));
          n_e++;
        end
      end
      if (ov_f && out_ready) begin
        if (q_f.size() == 0) chk("rand_f unexpected result", 1, 0);
        else begin
          exp_v = q_f.pop_front();
          chk("rand_f out", int'(out_f), int'(exp_v));
          n_f++;
        end
      end
    end
    chk("rand_e lost results", q_e.size(), 0);
    chk("rand_f lost results", q_f.size(), 0);
    $display("random: %0d results from early-exit instance, %0d from full-run instance", n_e, n_f);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
